// File: rtl/reg_file_pkg.sv
// Shared definitions for the scoreboarded register file: width helpers,
// the hardwired-zero address and the population count used for busy_cnt.
package reg_file_pkg;

    // Largest supported geometry; per-instance widths are slices of these.
    localparam int MAX_ADDR_W = 6;
    localparam int MAX_NREGS  = 1 << MAX_ADDR_W;
    localparam int MAX_XLEN   = 64;

    typedef logic [MAX_ADDR_W-1:0] reg_addr_t;
    typedef logic [MAX_XLEN-1:0]   reg_data_t;
    typedef logic [MAX_NREGS-1:0]  busy_vec_t;
    typedef logic [MAX_ADDR_W:0]   busy_cnt_t;

    localparam reg_addr_t ZERO_ADDR = '0;

    // Number of set bits in a (zero-extended) busy vector.
    function automatic busy_cnt_t popcount(input busy_vec_t v);
        busy_cnt_t c;
        c = '0;
        for (int i = 0; i < MAX_NREGS; i++) begin
            c = c + busy_cnt_t'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode-side bundle of the register file: two read ports with busy flags,
// one write port, the reserve/flush scoreboard controls and the busy count.
interface reg_file_sb_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] src_one;
    logic [ADDR_W-1:0] src_two;
    logic [XLEN-1:0]   out_one;
    logic [XLEN-1:0]   out_two;
    logic              busy_one;
    logic              busy_two;
    logic [ADDR_W-1:0] dest;
    logic              write_enable;
    logic [XLEN-1:0]   data_in;
    logic              reserve_en;
    logic [ADDR_W-1:0] reserve_addr;
    logic              flush;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output src_one, src_two, dest, write_enable, data_in,
               reserve_en, reserve_addr, flush,
        input  out_one, out_two, busy_one, busy_two, busy_cnt
    );

    modport slave (
        input  src_one, src_two, dest, write_enable, data_in,
               reserve_en, reserve_addr, flush,
        output out_one, out_two, busy_one, busy_two, busy_cnt
    );
endinterface

// File: rtl/reg_busy_tracker.sv
// Per-register busy scoreboard. Update priority per bit, lowest to highest:
// hold, flush clear, write clear, reserve set. busy_cnt is the registered
// population count of the vector that results from each edge.
module reg_busy_tracker
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_wr_en,
    input  logic [ADDR_W-1:0]      i_wr_addr,
    input  logic                   i_rsv_en,
    input  logic [ADDR_W-1:0]      i_rsv_addr,
    input  logic                   i_flush,
    output logic [(1<<ADDR_W)-1:0] o_busy_vec,
    output logic [ADDR_W:0]        o_busy_cnt
);
    localparam int NREGS = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [NREGS-1:0] r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [NREGS-1:0] w_next;

    // Next busy vector: later assignments override earlier ones (priority order).
    always_comb begin
        w_next = r_busy;
        if (i_flush)  w_next = '0;
        if (i_wr_en)  w_next[i_wr_addr] = 1'b0;
        if (i_rsv_en) w_next[i_rsv_addr] = 1'b1;
    end

    // Busy vector and its count move together so the count never lags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_next;
            r_cnt  <= CNT_W'(popcount(busy_vec_t'(w_next)));
        end
    end

    assign o_busy_vec = r_busy;
    assign o_busy_cnt = r_cnt;

endmodule

// File: rtl/reg_file_sb.sv
// Scoreboarded integer register file: 2^ADDR_W x XLEN, two combinational
// read ports, one synchronous write port, optional hardwired-zero r0 and
// optional same-cycle write-to-read bypass of both data and busy clear.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic       clk,
    input  logic       reset,
    reg_file_sb_if.slave bus
);
    localparam int                NREGS  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] L_ZERO = ZERO_ADDR[ADDR_W-1:0];

    logic [XLEN-1:0]   w_array [NREGS];
    logic [NREGS-1:0]  w_busy_vec;
    logic              w_wr_eff;
    logic              w_rsv_eff;
    logic              w_zero_one;
    logic              w_zero_two;
    logic              w_byp_one;
    logic              w_byp_two;
    logic [XLEN-1:0]   w_out_one;
    logic [XLEN-1:0]   w_out_two;
    logic              w_busy_one;
    logic              w_busy_two;

    // Writes and reserves aimed at a hardwired r0 are dropped here, so
    // neither the array nor the scoreboard ever sees them.
    assign w_wr_eff   = bus.write_enable && !((ZERO_REG != 0) && (bus.dest == L_ZERO));
    assign w_rsv_eff  = bus.reserve_en && !((ZERO_REG != 0) && (bus.reserve_addr == L_ZERO));

    assign w_zero_one = (ZERO_REG != 0) && (bus.src_one == L_ZERO);
    assign w_zero_two = (ZERO_REG != 0) && (bus.src_two == L_ZERO);
    assign w_byp_one  = (BYPASS != 0) && w_wr_eff && (bus.dest == bus.src_one);
    assign w_byp_two  = (BYPASS != 0) && w_wr_eff && (bus.dest == bus.src_two);

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        logic [XLEN-1:0] r_data;
        logic            w_sel;

        assign w_sel = w_wr_eff && (bus.dest == ADDR_W'(gi));

        // One storage word, loaded when this entry is the write target.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)     r_data <= '0;
            else if (w_sel) r_data <= bus.data_in;
        end

        assign w_array[gi] = r_data;
    end

    reg_busy_tracker #(
        .ADDR_W (ADDR_W)
    ) u_busy (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (w_wr_eff),
        .i_wr_addr  (bus.dest),
        .i_rsv_en   (w_rsv_eff),
        .i_rsv_addr (bus.reserve_addr),
        .i_flush    (bus.flush),
        .o_busy_vec (w_busy_vec),
        .o_busy_cnt (bus.busy_cnt)
    );

    // Read port 1: zero register wins, then in-flight write, then array.
    always_comb begin
        w_out_one  = w_array[bus.src_one];
        w_busy_one = w_busy_vec[bus.src_one];
        if (w_zero_one) begin
            w_out_one  = '0;
            w_busy_one = 1'b0;
        end else if (w_byp_one) begin
            w_out_one  = bus.data_in;
            w_busy_one = 1'b0;
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        w_out_two  = w_array[bus.src_two];
        w_busy_two = w_busy_vec[bus.src_two];
        if (w_zero_two) begin
            w_out_two  = '0;
            w_busy_two = 1'b0;
        end else if (w_byp_two) begin
            w_out_two  = bus.data_in;
            w_busy_two = 1'b0;
        end
    end

    assign bus.out_one  = w_out_one;
    assign bus.out_two  = w_out_two;
    assign bus.busy_one = w_busy_one;
    assign bus.busy_two = w_busy_two;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb across three configurations:
//   A: ADDR_W=5 ZERO_REG=1 BYPASS=1, B: ADDR_W=5 ZERO_REG=1 BYPASS=0,
//   C: ADDR_W=3 ZERO_REG=0 BYPASS=1.
module tb_reg_file_sb;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    reg_file_sb_if #(.XLEN(32), .ADDR_W(5)) ifa ();
    reg_file_sb_if #(.XLEN(32), .ADDR_W(5)) ifb ();
    reg_file_sb_if #(.XLEN(32), .ADDR_W(3)) ifc ();

    reg_file_sb #(.XLEN(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    reg_file_sb #(.XLEN(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave));
    reg_file_sb #(.XLEN(32), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut_c (
        .clk(clk), .reset(reset), .bus(ifc.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        ifa.write_enable = 0; ifa.reserve_en = 0; ifa.flush = 0;
        ifb.write_enable = 0; ifb.reserve_en = 0; ifb.flush = 0;
        ifc.write_enable = 0; ifc.reserve_en = 0; ifc.flush = 0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        ifa.src_one = '0; ifa.src_two = '0; ifa.dest = '0; ifa.data_in = '0; ifa.reserve_addr = '0;
        ifb.src_one = '0; ifb.src_two = '0; ifb.dest = '0; ifb.data_in = '0; ifb.reserve_addr = '0;
        ifc.src_one = '0; ifc.src_two = '0; ifc.dest = '0; ifc.data_in = '0; ifc.reserve_addr = '0;
        idle_all();
        tick();
        tick();
        chk("a_reset_cnt", ifa.busy_cnt, 0);
        chk("a_reset_out", ifa.out_one, 0);
        reset = 1'b1;
        tick();

        // Write r7, read it back; write to r0 is dropped.
        ifa.write_enable = 1; ifa.dest = 7; ifa.data_in = 32'hDEADBEEF;
        tick();
        idle_all();
        ifa.src_one = 7;
        #1 chk("a_rd_r7", ifa.out_one, 32'hDEADBEEF);
        ifa.write_enable = 1; ifa.dest = 0; ifa.data_in = 32'h1234; ifa.src_one = 0;
        #1 chk("a_r0_inflight", ifa.out_one, 0);
        tick();
        idle_all();
        #1 chk("a_r0_after", ifa.out_one, 0);

        // Bypass: seed r3 with an old value in A and B, then overwrite while reading.
        ifa.write_enable = 1; ifa.dest = 3; ifa.data_in = 32'h11111111;
        ifb.write_enable = 1; ifb.dest = 3; ifb.data_in = 32'h11111111;
        tick();
        ifa.data_in = 32'hA5A5A5A5; ifa.src_two = 3;
        ifb.data_in = 32'hA5A5A5A5; ifb.src_two = 3;
        #1 chk("a_bypass", ifa.out_two, 32'hA5A5A5A5);
        chk("b_nobypass_old", ifb.out_two, 32'h11111111);
        tick();
        idle_all();
        #1 chk("b_nobypass_next", ifb.out_two, 32'hA5A5A5A5);

        // Scoreboard: reserve r5 then r6 in A and B.
        ifa.reserve_en = 1; ifa.reserve_addr = 5;
        ifb.reserve_en = 1; ifb.reserve_addr = 5;
        tick();
        ifa.reserve_addr = 6; ifb.reserve_addr = 6;
        tick();
        idle_all();
        ifa.src_one = 5; ifb.src_one = 5;
        #1 chk("a_cnt2", ifa.busy_cnt, 2);
        chk("b_cnt2", ifb.busy_cnt, 2);
        chk("a_busy5", ifa.busy_one, 1);
        chk("b_busy5", ifb.busy_one, 1);
        ifa.write_enable = 1; ifa.dest = 5; ifa.data_in = 32'h55;
        ifb.write_enable = 1; ifb.dest = 5; ifb.data_in = 32'h55;
        #1 chk("a_busy5_wrcyc", ifa.busy_one, 0);
        chk("b_busy5_wrcyc", ifb.busy_one, 1);
        chk("a_out5_wrcyc", ifa.out_one, 32'h55);
        tick();
        idle_all();
        #1 chk("a_cnt1", ifa.busy_cnt, 1);
        chk("b_cnt1", ifb.busy_cnt, 1);
        chk("b_busy5_after", ifb.busy_one, 0);

        // Collision: reserve and write r9 together (r6 still busy).
        ifa.reserve_en = 1; ifa.reserve_addr = 9;
        ifa.write_enable = 1; ifa.dest = 9; ifa.data_in = 32'h99;
        tick();
        idle_all();
        ifa.src_one = 9;
        #1 chk("a_r9_data", ifa.out_one, 32'h99);
        chk("a_r9_busy", ifa.busy_one, 1);
        chk("a_cnt_r9", ifa.busy_cnt, 2);
        // Reserve has no same-cycle effect on the read busy flag.
        ifa.reserve_en = 1; ifa.reserve_addr = 5; ifa.src_one = 5;
        #1 chk("a_rsv_no_sameflag", ifa.busy_one, 0);
        tick();
        idle_all();
        #1 chk("a_cnt3", ifa.busy_cnt, 3);
        // Flush with reserve r4: only r4 survives.
        ifa.flush = 1; ifa.reserve_en = 1; ifa.reserve_addr = 4;
        tick();
        idle_all();
        ifa.src_one = 4; ifa.src_two = 5;
        #1 chk("a_flush_cnt", ifa.busy_cnt, 1);
        chk("a_flush_r4", ifa.busy_one, 1);
        chk("a_flush_r5", ifa.busy_two, 0);
        // Reserve of r0 is dropped when it is hardwired.
        ifa.reserve_en = 1; ifa.reserve_addr = 0;
        tick();
        idle_all();
        ifa.src_one = 0;
        #1 chk("a_rsv_r0_cnt", ifa.busy_cnt, 1);
        chk("a_rsv_r0_busy", ifa.busy_one, 0);

        // Saturation on C: reserve all 8, count reaches 8, then flush.
        for (int i = 0; i < 8; i++) begin
            ifc.reserve_en = 1; ifc.reserve_addr = 3'(i);
            tick();
        end
        idle_all();
        ifc.src_one = 0;
        #1 chk("c_cnt8", ifc.busy_cnt, 8);
        chk("c_r0_busy", ifc.busy_one, 1);
        ifc.reserve_en = 1; ifc.reserve_addr = 2;
        tick();
        idle_all();
        #1 chk("c_rsv_busy_again", ifc.busy_cnt, 8);
        ifc.flush = 1;
        tick();
        idle_all();
        #1 chk("c_flush_cnt0", ifc.busy_cnt, 0);

        // Reset mid-run with every register holding all ones and two busy.
        for (int i = 0; i < 8; i++) begin
            ifc.write_enable = 1; ifc.dest = 3'(i); ifc.data_in = 32'hFFFFFFFF;
            tick();
        end
        idle_all();
        ifc.reserve_en = 1; ifc.reserve_addr = 2;
        tick();
        ifc.reserve_addr = 3;
        tick();
        idle_all();
        ifc.src_one = 2; ifc.src_two = 3;
        #1 chk("c_pre_rst_out", ifc.out_one, 32'hFFFFFFFF);
        chk("c_pre_rst_cnt", ifc.busy_cnt, 2);
        reset = 1'b0;
        #1 chk("c_rst_out1", ifc.out_one, 0);
        chk("c_rst_out2", ifc.out_two, 0);
        chk("c_rst_busy1", ifc.busy_one, 0);
        chk("c_rst_busy2", ifc.busy_two, 0);
        chk("c_rst_cnt", ifc.busy_cnt, 0);
        // Writes and reserves are ignored while reset is held.
        ifc.write_enable = 1; ifc.dest = 1; ifc.data_in = 32'h5;
        ifc.reserve_en = 1; ifc.reserve_addr = 1;
        tick();
        idle_all();
        ifc.src_one = 1;
        #1 chk("c_rst_hold_out", ifc.out_one, 0);
        chk("c_rst_hold_cnt", ifc.busy_cnt, 0);
        reset = 1'b1;
        tick();
        #1 chk("c_post_rst_out", ifc.out_one, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
